// File: rtl/dcpu_dma_fetcher.sv
// Per-frame read-only DMA sweep mirroring DCPU memory regions into video RAMs.
// Optional DMA_FETCH_OVERRUN_EN adds overrun / overrun_cnt for ignored starts.
module dcpu_dma_fetcher #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NUM_CH = 3,
    parameter int LEN_W = 9,
    parameter logic [NUM_CH*LEN_W-1:0] CH_LEN =
        {9'd16, 9'd256, 9'd384},
    parameter logic [NUM_CH*ADDR_W-1:0] RST_BASE =
        {16'h0000, 16'h0000, 16'hF000},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              DMA_CLOCK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic [ADDR_W-1:0] DMA_addr,
    output logic [DATA_W-1:0] DMA_data,
    output logic              DMA_wren,
    input  logic [DATA_W-1:0] DMA_q,
    output logic              MIR_wren,
    output logic [CH_W-1:0]   MIR_ch,
    output logic [LEN_W-1:0]  MIR_addr,
    output logic [DATA_W-1:0] MIR_data,
    output logic              busy,
    output logic              done
`ifdef DMA_FETCH_OVERRUN_EN
    ,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_FETCH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state;
    logic [CH_W-1:0]   ch;
    logic [LEN_W-1:0]  off;
    logic [ADDR_W-1:0] base_q [NUM_CH];
    logic [ADDR_W-1:0] snap   [NUM_CH];
    logic              pipe_vld;
    logic [CH_W-1:0]   pipe_ch;
    logic [LEN_W-1:0]  pipe_off;
    logic [LEN_W-1:0]  cur_len;
    logic              last_ch;
    logic              last_off;
    logic              cfg_ok;

    assign cur_len  = CH_LEN[ch*LEN_W +: LEN_W];
    assign last_ch  = (32'(ch) == NUM_CH - 1);
    assign last_off = (off == cur_len - LEN_W'(1));
    assign cfg_ok   = cfg_we && (32'(cfg_ch) < NUM_CH);

    always_ff @(posedge DMA_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++)
                base_q[i] <= RST_BASE[i*ADDR_W +: ADDR_W];
        end else if (cfg_ok) begin
            base_q[cfg_ch] <= cfg_base;
        end
    end

    // snap is taken from pre-edge base_q, so a same-edge write lands next sweep
    always_ff @(posedge DMA_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            ch       <= '0;
            off      <= '0;
            pipe_vld <= 1'b0;
            pipe_ch  <= '0;
            pipe_off <= '0;
            for (int i = 0; i < NUM_CH; i++)
                snap[i] <= '0;
        end else begin
            pipe_vld <= (state == S_FETCH);
            pipe_ch  <= ch;
            pipe_off <= off;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CH; i++)
                            snap[i] <= base_q[i];
                        ch    <= '0;
                        off   <= '0;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    off <= '0;
                    if (snap[ch] != '0)
                        state <= S_FETCH;
                    else if (last_ch)
                        state <= S_DONE;
                    else
                        ch <= ch + CH_W'(1);
                end
                S_FETCH: begin
                    if (last_off) begin
                        if (last_ch) begin
                            state <= S_DONE;
                        end else begin
                            ch    <= ch + CH_W'(1);
                            state <= S_SELECT;
                        end
                    end else begin
                        off <= off + LEN_W'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign DMA_addr = (state == S_FETCH) ? snap[ch] + ADDR_W'(off) : '0;
    assign DMA_data = '0;
    assign DMA_wren = 1'b0;
    assign MIR_wren = pipe_vld;
    assign MIR_ch   = pipe_vld ? pipe_ch : '0;
    assign MIR_addr = pipe_vld ? pipe_off : '0;
    assign MIR_data = pipe_vld ? DMA_q : '0;

`ifdef DMA_FETCH_OVERRUN_EN
    always_ff @(posedge DMA_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (start && busy) begin
            overrun <= 1'b1;
            if (overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
